// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and helpers for the single-clock FIFO controller.
//   fifo_depth(asize)  : number of storage words, 2**asize
//   count_width(asize) : width of occupancy count and pointers, asize+1
//   FWFT_STD / FWFT_FALL : read-mode selector values for the FWFT parameter
package sync_fifo_ctrl_pkg;

    localparam int FWFT_STD  = 0;
    localparam int FWFT_FALL = 1;

    function automatic int fifo_depth(input int asize);
        return 32'sd1 << asize;
    endfunction

    function automatic int count_width(input int asize);
        return asize + 32'sd1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DSIZE storage array for the single-clock FIFO.
// Ports:
//   clk     : write clock, rising edge
//   wr_en   : write strobe; wr_data stored at wr_addr on the edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (asynchronous read)
//   rd_data : word currently stored at rd_addr
// Contents are intentionally not reset.
module sync_fifo_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    logic [DSIZE-1:0] mem_q [1 << ASIZE];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with integrated storage.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-low reset
//   wr_data/wr_inc: write word and write request
//   rd_inc        : read request (pop)
//   flush         : synchronous clear of pointers and count
//   err_clr       : synchronous clear of sticky overflow/underflow
//   rd_data       : read word (registered in standard mode, head-of-queue in FWFT mode)
//   wr_full, wr_afull, rd_empty, rd_aempty : status flags decoded from occupancy
//   count         : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = (1 << ASIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_inc,
    input  logic             rd_inc,
    input  logic             flush,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rd_data,
    output logic             wr_full,
    output logic             wr_afull,
    output logic             rd_empty,
    output logic             rd_aempty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifo_depth(ASIZE);
    localparam int CW    = count_width(ASIZE);

    localparam logic [CW-1:0]    ZERO_C  = '0;
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]    AE_C    = CW'(AE_LEVEL);
    localparam logic [DSIZE-1:0] DZERO_C = '0;

    // Reject illegal threshold settings while elaborating
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH) || (AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_levels
        $error("sync_fifo_ctrl: AF_LEVEL/AE_LEVEL out of range");
    end

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_full_q, wr_full_d;
    logic             wr_afull_q, wr_afull_d;
    logic             rd_empty_q, rd_empty_d;
    logic             rd_aempty_q, rd_aempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [DSIZE-1:0] rd_data_q, rd_data_d;

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [DSIZE-1:0] ram_rdata_s;
    logic [DSIZE-1:0] rd_data_s;

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_q[ASIZE-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q[ASIZE-1:0]),
        .rd_data (ram_rdata_s)
    );

    // Next-state: acceptance, pointers, occupancy, flags, sticky errors, read register
    always_comb begin
        // Acceptance looks only at the registered flags, so a same-cycle pop
        // never makes room for a push into a full FIFO. Flush suppresses both.
        wr_acc_s    = wr_inc && !wr_full_q && !flush;
        rd_acc_s    = rd_inc && !rd_empty_q && !flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_data_d   = rd_data_q;

        if (flush) begin
            wr_ptr_d = ZERO_C;
            rd_ptr_d = ZERO_C;
            count_d  = ZERO_C;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end

        // Standard mode: capture the head word on an accepted pop, else hold
        if (rd_acc_s) begin
            rd_data_d = ram_rdata_s;
        end else begin
            rd_data_d = rd_data_q;
        end

        // Sticky errors: a new event wins over a same-cycle clear; flush never sets them
        if (wr_inc && wr_full_q && !flush) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_inc && rd_empty_q && !flush) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end

        // Flags are decoded from next count and registered alongside it
        wr_full_d   = (count_d == DEPTH_C);
        wr_afull_d  = (count_d >= AF_C);
        rd_empty_d  = (count_d == ZERO_C);
        rd_aempty_d = (count_d <= AE_C);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            count_q     <= ZERO_C;
            wr_full_q   <= 1'b0;
            wr_afull_q  <= 1'b0;
            rd_empty_q  <= 1'b1;
            rd_aempty_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= DZERO_C;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_full_q   <= wr_full_d;
            wr_afull_q  <= wr_afull_d;
            rd_empty_q  <= rd_empty_d;
            rd_aempty_q <= rd_aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Read-data selection: FWFT shows the head word directly, forced to zero when empty
    always_comb begin
        rd_data_s = rd_data_q;
        if (FWFT == FWFT_FALL) begin
            if (rd_empty_q) begin
                rd_data_s = DZERO_C;
            end else begin
                rd_data_s = ram_rdata_s;
            end
        end else begin
            rd_data_s = rd_data_q;
        end
    end

    assign rd_data   = rd_data_s;
    assign wr_full   = wr_full_q;
    assign wr_afull  = wr_afull_q;
    assign rd_empty  = rd_empty_q;
    assign rd_aempty = rd_aempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-read instance and one FWFT instance
// share the same stimulus; each task checks its own scenario.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_inc;
    logic       rd_inc;
    logic       flush;
    logic       err_clr;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
    logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int n_tests;
    int n_fail;

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc),
        .flush(flush), .err_clr(err_clr), .rd_data(s_rd_data), .wr_full(s_full),
        .wr_afull(s_afull), .rd_empty(s_empty), .rd_aempty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc),
        .flush(flush), .err_clr(err_clr), .rd_data(f_rd_data), .wr_full(f_full),
        .wr_afull(f_afull), .rd_empty(f_empty), .rd_aempty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_inc = 1'b0; rd_inc = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        idle(); wr_inc = 1'b1; wr_data = v; tick(); idle();
    endtask

    task automatic pop();
        idle(); rd_inc = 1'b1; tick(); idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #12;
        n_tests++; if (s_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", s_count); end
        n_tests++; if ({s_empty, s_aempty, s_full, s_afull} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got %b exp 1100", {s_empty, s_aempty, s_full, s_afull}); end
        n_tests++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {s_ovf, s_unf}); end
        n_tests++; if (s_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", s_rd_data); end
        n_tests++; if ({f_rd_data, f_empty} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL reset_fwft got %h/%b exp 00/1", f_rd_data, f_empty); end
        @(posedge clk); #1; rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            n_tests++; if (s_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_count, i + 1); end
            n_tests++; if (s_afull !== ((i + 1) >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, s_afull, (i + 1) >= 14); end
            n_tests++; if (s_full !== ((i + 1) == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, s_full, (i + 1) == 16); end
        end
        for (int i = 0; i < 16; i++) begin
            pop();
            n_tests++; if (s_rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, s_rd_data, 8'(i)); end
            n_tests++; if (s_count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, s_count, 15 - i); end
            n_tests++; if (s_empty !== (i == 15)) begin n_fail++; $display("FAIL drain_empty[%0d] got %b exp %b", i, s_empty, i == 15); end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        push(8'hAA);
        n_tests++; if ({s_count, s_ovf} !== {5'd16, 1'b1}) begin n_fail++; $display("FAIL ovf_set got %0d/%b exp 16/1", s_count, s_ovf); end
        tick();
        n_tests++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", s_ovf); end
        err_clr = 1'b1; tick(); idle();
        n_tests++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", s_ovf); end
        for (int i = 0; i < 16; i++) begin
            pop();
            n_tests++; if (s_rd_data !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL ovf_data[%0d] got %h exp %h", i, s_rd_data, 8'(8'h10 + i)); end
        end
        pop();
        n_tests++; if ({s_unf, s_rd_data} !== {1'b1, 8'h1F}) begin n_fail++; $display("FAIL unf_set got %b/%h exp 1/1f", s_unf, s_rd_data); end
        err_clr = 1'b1; tick(); idle();
        n_tests++; if (s_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", s_unf); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            wr_inc = 1'b1; rd_inc = 1'b1; wr_data = 8'(8'h45 + i);
            tick();
            n_tests++; if (s_count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 5", i, s_count); end
            n_tests++; if (s_rd_data !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", i, s_rd_data, 8'(8'h40 + i)); end
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            pop();
            n_tests++; if (s_rd_data !== 8'(8'h68 + i)) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, s_rd_data, 8'(8'h68 + i)); end
        end
    endtask

    task automatic test_simultaneous();
        wr_inc = 1'b1; rd_inc = 1'b1; wr_data = 8'h3C; tick(); idle();
        n_tests++; if ({s_count, s_unf, s_rd_data} !== {5'd1, 1'b1, 8'h6C}) begin n_fail++; $display("FAIL empty_wr_rd got %0d/%b/%h exp 1/1/6c", s_count, s_unf, s_rd_data); end
        err_clr = 1'b1; tick(); idle();
        pop();
        n_tests++; if (s_rd_data !== 8'h3C) begin n_fail++; $display("FAIL empty_wr_rd_data got %h exp 3c", s_rd_data); end
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        wr_inc = 1'b1; rd_inc = 1'b1; wr_data = 8'hEE; tick(); idle();
        n_tests++; if ({s_count, s_rd_data, s_ovf} !== {5'd15, 8'h80, 1'b1}) begin n_fail++; $display("FAIL full_wr_rd got %0d/%h/%b exp 15/80/1", s_count, s_rd_data, s_ovf); end
        err_clr = 1'b1; tick(); idle();
        for (int i = 1; i < 16; i++) begin
            pop();
            n_tests++; if (s_rd_data !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL full_wr_rd_data[%0d] got %h exp %h", i, s_rd_data, 8'(8'h80 + i)); end
        end
        n_tests++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL full_wr_rd_empty got %b exp 1", s_empty); end
    endtask

    task automatic test_fwft();
        rst = 1'b0; #3; rst = 1'b1; tick();
        push(8'h55);
        n_tests++; if ({f_rd_data, f_empty} !== {8'h55, 1'b0}) begin n_fail++; $display("FAIL fwft_first got %h/%b exp 55/0", f_rd_data, f_empty); end
        push(8'h66);
        n_tests++; if (f_rd_data !== 8'h55) begin n_fail++; $display("FAIL fwft_head got %h exp 55", f_rd_data); end
        pop();
        n_tests++; if (f_rd_data !== 8'h66) begin n_fail++; $display("FAIL fwft_next got %h exp 66", f_rd_data); end
        pop();
        n_tests++; if ({f_rd_data, f_empty} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL fwft_empty got %h/%b exp 00/1", f_rd_data, f_empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) push(8'(8'h90 + i));
        n_tests++; if (s_count !== 5'd9) begin n_fail++; $display("FAIL flush_pre got %0d exp 9", s_count); end
        flush = 1'b1; wr_inc = 1'b1; wr_data = 8'hBB; tick(); idle();
        n_tests++; if ({s_count, s_empty, s_ovf} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush_state got %0d/%b/%b exp 0/1/0", s_count, s_empty, s_ovf); end
        n_tests++; if ({f_rd_data, f_count} !== {8'h00, 5'd0}) begin n_fail++; $display("FAIL flush_fwft got %h/%0d exp 00/0", f_rd_data, f_count); end
        push(8'h11);
        pop();
        n_tests++; if ({s_rd_data, s_empty} !== {8'h11, 1'b1}) begin n_fail++; $display("FAIL flush_after got %h/%b exp 11/1", s_rd_data, s_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        wr_inc = 1'b1; wr_data = 8'hA6;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_tests++; if ({s_count, s_empty, s_aempty, s_full} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL midrst_state got %0d/%b/%b/%b exp 0/1/1/0", s_count, s_empty, s_aempty, s_full); end
        n_tests++; if ({s_rd_data, f_rd_data} !== 16'h0000) begin n_fail++; $display("FAIL midrst_data got %h/%h exp 00/00", s_rd_data, f_rd_data); end
        idle();
        @(posedge clk); #1; rst = 1'b1;
        tick();
        n_tests++; if ({s_count, f_count} !== 10'd0) begin n_fail++; $display("FAIL midrst_after got %0d/%0d exp 0/0", s_count, f_count); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        wr_data = 8'h00;
        idle();
        test_reset();
        test_fill_drain();
        test_errors();
        test_back_to_back();
        test_simultaneous();
        test_fwft();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
